// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the second-generation system controller:
// command opcodes, the controller state encoding and the default error byte.
package sys_ctrl_pkg;

    localparam logic [7:0] OP_WRITE   = 8'hAA;  // RF write: addr, data
    localparam logic [7:0] OP_READ    = 8'hBB;  // RF single read: addr
    localparam logic [7:0] OP_BURST   = 8'hBC;  // RF burst read: addr, count
    localparam logic [7:0] OP_ALU     = 8'hCC;  // ALU with operands: A, B, fun
    localparam logic [7:0] OP_ALU_NOP = 8'hDD;  // ALU on current operands: fun

    localparam logic [7:0] DEF_ERR_CODE = 8'hEE;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        GET_ADDR = 4'd1,
        GET_DATA = 4'd2,
        GET_CNT  = 4'd3,
        GET_A    = 4'd4,
        GET_B    = 4'd5,
        GET_FUN  = 4'd6,
        LOAD_A   = 4'd7,
        LOAD_B   = 4'd8,
        ALU_WAIT = 4'd9,
        RD_REQ   = 4'd10,
        RD_WAIT  = 4'd11,
        SEND_RD  = 4'd12,
        SEND_ALU = 4'd13,
        SEND_ERR = 4'd14
    } state_t;

endpackage

// File: rtl/sys_ctrl_v2_if.sv
// Bundle of every signal between the controller and its neighbours
// (UART RX, register file, ALU, TX FIFO), plus a state debug tap.
//
// Handshakes: RX_D_VLD, Rd_DATA_Valid and ALU_OUT_Valid are one-cycle
// strobes with no back-pressure; their data is valid only in the strobe
// cycle. A TX byte transfers on a rising CLK where TX_D_VLD=1 and
// FIFO_FULL=0; while FIFO_FULL=1 the controller keeps TX_D_VLD and
// TX_P_DATA stable until the transfer happens.
interface sys_ctrl_v2_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_OUT_WIDTH = 16
);
    import sys_ctrl_pkg::*;

    logic [DATA_WIDTH-1:0]    RX_P_DATA;
    logic                     RX_D_VLD;
    logic [ALU_OUT_WIDTH-1:0] ALU_OUT;
    logic                     ALU_OUT_Valid;
    logic [3:0]               ALU_FUN;
    logic                     ALU_EN;
    logic                     CLK_EN;
    logic [DATA_WIDTH-1:0]    Rd_DATA;
    logic                     Rd_DATA_Valid;
    logic [DATA_WIDTH-1:0]    WR_DATA;
    logic                     WR_EN;
    logic                     RD_EN;
    logic [ADDR_WIDTH-1:0]    Address;
    logic [DATA_WIDTH-1:0]    TX_P_DATA;
    logic                     TX_D_VLD;
    logic                     FIFO_FULL;
    logic                     CMD_ERR;
    state_t                   dbg_state;

    // Controller side
    modport master (
        input  RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_Valid,
               Rd_DATA, Rd_DATA_Valid, FIFO_FULL,
        output ALU_FUN, ALU_EN, CLK_EN, WR_DATA, WR_EN, RD_EN, Address,
               TX_P_DATA, TX_D_VLD, CMD_ERR, dbg_state
    );

    // Environment side (RX, RF, ALU, TX FIFO)
    modport slave (
        output RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_Valid,
               Rd_DATA, Rd_DATA_Valid, FIFO_FULL,
        input  ALU_FUN, ALU_EN, CLK_EN, WR_DATA, WR_EN, RD_EN, Address,
               TX_P_DATA, TX_D_VLD, CMD_ERR, dbg_state
    );

endinterface

// File: rtl/sys_ctrl_timeout.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags
// expiry once TIMEOUT_CYCLES is reached. Saturates so it never wraps.
module sys_ctrl_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    // Clear wins over counting; hold at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == LIMIT);

endmodule

// File: rtl/sys_ctrl_v2.sv
// System controller: decodes RX command frames into RF writes, single and
// burst RF reads and ALU operations, returns results byte-wise to the TX
// FIFO, and answers bad, empty or stalled frames with an error byte.
module sys_ctrl_v2
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_OUT_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_CODE = DATA_WIDTH'(DEF_ERR_CODE)
) (
    input logic           CLK,
    input logic           RST,
    sys_ctrl_v2_if.master bus
);

    localparam int NB    = ALU_OUT_WIDTH / DATA_WIDTH;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    state_t                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    opcode_q, opcode_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    cnt_q, cnt_d;
    logic [3:0]               fun_q, fun_d;
    logic [DATA_WIDTH-1:0]    op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0]    op_b_q, op_b_d;
    logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;
    logic [ALU_OUT_WIDTH-1:0] alu_res_q, alu_res_d;
    logic [IDX_W-1:0]         idx_q, idx_d;

    logic                     is_get, rx_accept;
    logic                     tmo_en, tmo_clr, tmo_expired;

    logic [3:0]               alu_fun;
    logic                     alu_en, clk_en, wr_en, rd_en, tx_vld, cmd_err;
    logic [DATA_WIDTH-1:0]    wr_data, tx_data;
    logic [ADDR_WIDTH-1:0]    address;

    assign is_get    = state_q inside {GET_ADDR, GET_DATA, GET_CNT, GET_A, GET_B, GET_FUN};
    assign rx_accept = is_get && bus.RX_D_VLD;
    assign tmo_en    = is_get || (state_q == RD_WAIT) || (state_q == ALU_WAIT);
    assign tmo_clr   = (state_d != state_q) || rx_accept;

    sys_ctrl_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (CLK),
        .rst_n   (RST),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    // Next-state, datapath capture and output decode; strobes beat timeouts
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        fun_d     = fun_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        rd_data_d = rd_data_q;
        alu_res_d = alu_res_q;
        idx_d     = idx_q;
        alu_fun   = 4'd0;
        alu_en    = 1'b0;
        clk_en    = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        wr_data   = '0;
        address   = addr_q;
        tx_vld    = 1'b0;
        tx_data   = '0;
        cmd_err   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.RX_D_VLD) begin
                    opcode_d = bus.RX_P_DATA;
                    case (bus.RX_P_DATA)
                        OP_WRITE, OP_READ, OP_BURST: state_d = GET_ADDR;
                        OP_ALU:                      state_d = GET_A;
                        OP_ALU_NOP:                  state_d = GET_FUN;
                        default:                     state_d = SEND_ERR;
                    endcase
                end
            end
            GET_ADDR: begin
                if (bus.RX_D_VLD) begin
                    addr_d = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    if (opcode_q == OP_WRITE) begin
                        state_d = GET_DATA;
                    end else if (opcode_q == OP_BURST) begin
                        state_d = GET_CNT;
                    end else begin
                        cnt_d   = DATA_WIDTH'(1);
                        state_d = RD_REQ;
                    end
                end else if (tmo_expired) begin
                    state_d = SEND_ERR;
                end
            end
            GET_DATA: begin
                if (bus.RX_D_VLD) begin
                    wr_en   = 1'b1;
                    wr_data = bus.RX_P_DATA;
                    state_d = IDLE;
                end else if (tmo_expired) begin
                    state_d = SEND_ERR;
                end
            end
            GET_CNT: begin
                if (bus.RX_D_VLD) begin
                    if (bus.RX_P_DATA == '0) begin
                        state_d = SEND_ERR;
                    end else begin
                        cnt_d   = bus.RX_P_DATA;
                        state_d = RD_REQ;
                    end
                end else if (tmo_expired) begin
                    state_d = SEND_ERR;
                end
            end
            GET_A: begin
                if (bus.RX_D_VLD) begin
                    op_a_d  = bus.RX_P_DATA;
                    state_d = GET_B;
                end else if (tmo_expired) begin
                    state_d = SEND_ERR;
                end
            end
            GET_B: begin
                if (bus.RX_D_VLD) begin
                    op_b_d  = bus.RX_P_DATA;
                    state_d = GET_FUN;
                end else if (tmo_expired) begin
                    state_d = SEND_ERR;
                end
            end
            GET_FUN: begin
                if (bus.RX_D_VLD) begin
                    fun_d   = bus.RX_P_DATA[3:0];
                    state_d = (opcode_q == OP_ALU) ? LOAD_A : ALU_WAIT;
                end else if (tmo_expired) begin
                    state_d = SEND_ERR;
                end
            end
            LOAD_A: begin
                wr_en   = 1'b1;
                clk_en  = 1'b1;
                address = ADDR_WIDTH'(0);
                wr_data = op_a_q;
                state_d = LOAD_B;
            end
            LOAD_B: begin
                wr_en   = 1'b1;
                clk_en  = 1'b1;
                address = ADDR_WIDTH'(1);
                wr_data = op_b_q;
                state_d = ALU_WAIT;
            end
            ALU_WAIT: begin
                alu_en  = 1'b1;
                clk_en  = 1'b1;
                alu_fun = fun_q;
                if (bus.ALU_OUT_Valid) begin
                    alu_res_d = bus.ALU_OUT;
                    idx_d     = '0;
                    state_d   = SEND_ALU;
                end else if (tmo_expired) begin
                    state_d = SEND_ERR;
                end
            end
            RD_REQ: begin
                rd_en   = 1'b1;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.Rd_DATA_Valid) begin
                    rd_data_d = bus.Rd_DATA;
                    state_d   = SEND_RD;
                end else if (tmo_expired) begin
                    state_d = SEND_ERR;
                end
            end
            SEND_RD: begin
                tx_vld  = 1'b1;
                tx_data = rd_data_q;
                if (!bus.FIFO_FULL) begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    cnt_d   = cnt_q - DATA_WIDTH'(1);
                    state_d = (cnt_q == DATA_WIDTH'(1)) ? IDLE : RD_REQ;
                end
            end
            SEND_ALU: begin
                tx_vld  = 1'b1;
                tx_data = alu_res_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
                if (!bus.FIFO_FULL) begin
                    if (idx_q == IDX_W'(NB - 1)) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            SEND_ERR: begin
                tx_vld  = 1'b1;
                tx_data = ERR_CODE;
                if (!bus.FIFO_FULL) begin
                    cmd_err = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            opcode_q  <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            fun_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            rd_data_q <= '0;
            alu_res_q <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            fun_q     <= fun_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            rd_data_q <= rd_data_d;
            alu_res_q <= alu_res_d;
            idx_q     <= idx_d;
        end
    end

    assign bus.ALU_FUN   = alu_fun;
    assign bus.ALU_EN    = alu_en;
    assign bus.CLK_EN    = clk_en;
    assign bus.WR_DATA   = wr_data;
    assign bus.WR_EN     = wr_en;
    assign bus.RD_EN     = rd_en;
    assign bus.Address   = address;
    assign bus.TX_P_DATA = tx_data;
    assign bus.TX_D_VLD  = tx_vld;
    assign bus.CMD_ERR   = cmd_err;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_sys_ctrl_v2.sv
// Bench for sys_ctrl_v2: a 16-bit-result instance with a short timeout
// against RF/ALU/TX models, plus a 24-bit-result instance for byte order.
module tb_sys_ctrl_v2;
    import sys_ctrl_pkg::*;

    localparam int         TMO = 16;
    localparam logic [7:0] EE  = 8'hEE;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic en24  = 1'b0;

    always #5 clk = ~clk;

    sys_ctrl_v2_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_OUT_WIDTH(16)) bus ();
    sys_ctrl_v2_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_OUT_WIDTH(24)) bus24 ();

    sys_ctrl_v2 #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_OUT_WIDTH(16),
        .TIMEOUT_CYCLES(TMO), .ERR_CODE(EE)
    ) u_dut (
        .CLK(clk), .RST(rst_n), .bus(bus)
    );

    sys_ctrl_v2 #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_OUT_WIDTH(24)
    ) u_dut24 (
        .CLK(clk), .RST(rst_n), .bus(bus24)
    );

    // 24-bit instance sees RX only while en24; its ALU answers at once
    assign bus24.RX_P_DATA     = bus.RX_P_DATA;
    assign bus24.RX_D_VLD      = bus.RX_D_VLD & en24;
    assign bus24.ALU_OUT       = 24'hABCDEF;
    assign bus24.ALU_OUT_Valid = bus24.ALU_EN;
    assign bus24.Rd_DATA       = 8'h00;
    assign bus24.Rd_DATA_Valid = 1'b0;
    assign bus24.FIFO_FULL     = 1'b0;

    // ---------------- scoreboard state ----------------
    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp24_q[$];
    logic [11:0] exp_wr_q[$];
    logic [3:0]  exp_rd_q[$];
    int          tx_cnt = 0, tx_exp_cnt = 0;
    int          wr_cnt = 0, wr_exp_cnt = 0;
    int          rd_cnt = 0, rd_exp_cnt = 0;
    int          tx24_cnt = 0;
    logic [7:0]  shadow[16];
    logic [7:0]  rf[16];
    logic [3:0]  exp_fun = 4'd0;
    logic [15:0] alu_result = 16'h0;
    int          alu_wait_cnt = 0;
    logic        rd_pending = 1'b0;
    logic [7:0]  rd_hold = 8'h00;
    logic [7:0]  mon_e, mon_e24;
    logic [11:0] mon_w;
    logic [3:0]  mon_a;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- monitors and environment models ----------------
    always @(negedge clk) begin
        // sample
        if (bus.TX_D_VLD && !bus.FIFO_FULL) begin
            tx_cnt++;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check_eq("tx_byte", 32'(bus.TX_P_DATA), 32'(mon_e));
                check_eq("cmd_err", 32'(bus.CMD_ERR), 32'(mon_e == EE));
            end
        end
        if (bus24.TX_D_VLD) begin
            tx24_cnt++;
            if (exp24_q.size() > 0) begin
                mon_e24 = exp24_q.pop_front();
                check_eq("tx24_byte", 32'(bus24.TX_P_DATA), 32'(mon_e24));
            end
        end
        if (bus.WR_EN) begin
            wr_cnt++;
            rf[bus.Address] = bus.WR_DATA;
            if (exp_wr_q.size() > 0) begin
                mon_w = exp_wr_q.pop_front();
                check_eq("rf_write", 32'({bus.Address, bus.WR_DATA}), 32'(mon_w));
            end
        end
        if (bus.ALU_EN) begin
            check_eq("alu_fun", 32'(bus.ALU_FUN), 32'(exp_fun));
            check_eq("alu_clk_en", 32'(bus.CLK_EN), 32'd1);
        end
        // drive: RF read answers one cycle after the request
        if (rd_pending) begin
            bus.Rd_DATA_Valid = 1'b1;
            bus.Rd_DATA       = rd_hold;
            rd_pending        = 1'b0;
        end else begin
            bus.Rd_DATA_Valid = 1'b0;
        end
        if (bus.RD_EN) begin
            rd_cnt++;
            rd_pending = 1'b1;
            rd_hold    = rf[bus.Address];
            if (exp_rd_q.size() > 0) begin
                mon_a = exp_rd_q.pop_front();
                check_eq("rd_addr", 32'(bus.Address), 32'(mon_a));
            end
        end
        // drive: ALU answers on the fourth enabled cycle
        if (bus.ALU_EN) begin
            bus.ALU_OUT       = alu_result;
            bus.ALU_OUT_Valid = (alu_wait_cnt == 3);
            alu_wait_cnt++;
        end else begin
            bus.ALU_OUT_Valid = 1'b0;
            alu_wait_cnt      = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        @(posedge clk); #1;
        bus.RX_D_VLD  = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        exp_wr_q.push_back({a, d});
        wr_exp_cnt++;
        shadow[a] = d;
        send_byte(OP_WRITE);
        send_byte({4'h0, a});
        send_byte(d);
    endtask

    task automatic do_burst(input logic [3:0] a, input logic [7:0] n, input logic single);
        logic [3:0] ad;
        ad = a;
        for (int i = 0; i < int'(n); i++) begin
            exp_rd_q.push_back(ad);
            rd_exp_cnt++;
            exp_q.push_back(shadow[ad]);
            tx_exp_cnt++;
            ad = ad + 4'd1;
        end
        send_byte(single ? OP_READ : OP_BURST);
        send_byte({4'h0, a});
        if (!single) send_byte(n);
    endtask

    task automatic do_alu(input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] f, input logic [15:0] res);
        exp_wr_q.push_back({4'd0, a});
        exp_wr_q.push_back({4'd1, b});
        wr_exp_cnt += 2;
        shadow[0]  = a;
        shadow[1]  = b;
        exp_fun    = f;
        alu_result = res;
        exp_q.push_back(res[7:0]);
        exp_q.push_back(res[15:8]);
        tx_exp_cnt += 2;
        send_byte(OP_ALU);
        send_byte(a);
        send_byte(b);
        send_byte({4'h0, f});
    endtask

    task automatic do_alu_nop(input logic [3:0] f, input logic [15:0] res);
        exp_fun    = f;
        alu_result = res;
        exp_q.push_back(res[7:0]);
        exp_q.push_back(res[15:8]);
        tx_exp_cnt += 2;
        send_byte(OP_ALU_NOP);
        send_byte({4'h0, f});
    endtask

    task automatic expect_err();
        exp_q.push_back(EE);
        tx_exp_cnt++;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && exp24_q.size() == 0 && bus.dbg_state == IDLE) break;
        end
        check_eq({"pending_", tag}, 32'(exp_q.size() + exp24_q.size()), 32'd0);
        check_eq({"idle_", tag}, 32'(bus.dbg_state), 32'(IDLE));
    endtask

    task automatic wait_state(input state_t s, input string tag);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.dbg_state == s) break;
        end
        check_eq({"reach_", tag}, 32'(bus.dbg_state), 32'(s));
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({bus.ALU_FUN, bus.ALU_EN, bus.CLK_EN, bus.WR_DATA, bus.WR_EN,
                    bus.RD_EN, bus.Address, bus.TX_P_DATA, bus.TX_D_VLD, bus.CMD_ERR});
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 16; i++) begin
            shadow[i] = 8'h00;
            rf[i]     = 8'h00;
        end
        bus.RX_P_DATA = 8'h00;
        bus.RX_D_VLD  = 1'b0;
        bus.FIFO_FULL = 1'b0;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_outputs", out_vec(), 32'd0);
        check_eq("reset_state", 32'(bus.dbg_state), 32'(IDLE));
        @(posedge clk); #1 rst_n = 1'b1;

        // write then single read
        do_write(4'd5, 8'h3C);
        do_burst(4'd5, 8'd1, 1'b1);
        wait_idle("wr_rd");

        // ALU with operands; 24-bit instance listens to the same frame
        exp24_q.push_back(8'hEF);
        exp24_q.push_back(8'hCD);
        exp24_q.push_back(8'hAB);
        en24 = 1'b1;
        do_alu(8'h07, 8'h09, 4'h0, 16'h0010);
        en24 = 1'b0;
        wait_idle("alu");

        // ALU without operands
        do_alu_nop(4'h3, 16'hBEEF);
        wait_idle("alu_nop");

        // burst read across the address wrap
        do_write(4'd14, 8'hA1);
        do_write(4'd15, 8'hB2);
        do_write(4'd0, 8'hC3);
        do_burst(4'd14, 8'd3, 1'b0);
        wait_idle("burst");

        // back-pressure held longer than the timeout during SEND_ALU
        @(posedge clk); #1 bus.FIFO_FULL = 1'b1;
        do_alu(8'h12, 8'h34, 4'h2, 16'h0046);
        wait_state(SEND_ALU, "bp");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("bp_vld", 32'(bus.TX_D_VLD), 32'd1);
            check_eq("bp_data", 32'(bus.TX_P_DATA), 32'h46);
            check_eq("bp_state", 32'(bus.dbg_state), 32'(SEND_ALU));
        end
        @(posedge clk); #1 bus.FIFO_FULL = 1'b0;
        wait_idle("bp");

        // unknown opcode
        expect_err();
        send_byte(8'h55);
        wait_idle("bad_op");

        // write frame abandoned after the address byte
        expect_err();
        send_byte(OP_WRITE);
        send_byte(8'h03);
        wait_idle("timeout");

        // burst with zero count
        expect_err();
        send_byte(OP_BURST);
        send_byte(8'h02);
        send_byte(8'h00);
        wait_idle("zero_cnt");

        // reset while a burst byte is stalled in SEND_RD
        @(posedge clk); #1 bus.FIFO_FULL = 1'b1;
        exp_rd_q.push_back(4'd0);
        rd_exp_cnt++;
        send_byte(OP_BURST);
        send_byte(8'h00);
        send_byte(8'h04);
        wait_state(SEND_RD, "rst_burst");
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_outputs", out_vec(), 32'd0);
        check_eq("midrst_state", 32'(bus.dbg_state), 32'(IDLE));
        repeat (2) @(posedge clk);
        #1;
        bus.FIFO_FULL = 1'b0;
        rst_n = 1'b1;
        do_burst(4'd1, 8'd1, 1'b1);
        wait_idle("post_rst");

        repeat (5) @(negedge clk);
        check_eq("tx_count", 32'(tx_cnt), 32'(tx_exp_cnt));
        check_eq("wr_count", 32'(wr_cnt), 32'(wr_exp_cnt));
        check_eq("rd_count", 32'(rd_cnt), 32'(rd_exp_cnt));
        check_eq("tx24_count", 32'(tx24_cnt), 32'd3);
        check_eq("left_wr", 32'(exp_wr_q.size()), 32'd0);
        check_eq("left_rd", 32'(exp_rd_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got no end expected end");
        $fatal(1, "watchdog");
    end

endmodule
